// File: rtl/serial_bit_feeder_if.sv
// Bus bundle between a word producer, the serial bit feeder and the
// downstream pattern detector. The feeder is the slave on the word side and
// the source of the serial stream.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             shift_en;
  logic             x_out;
  logic             x_valid;
  logic             x_last;
  logic             busy;

  // Producer side: offers words and paces the bit rate.
  modport master (
    output din, din_valid, shift_en,
    input  din_ready, x_out, x_valid, x_last, busy
  );

  // Feeder side: accepts words and emits the serial stream.
  modport slave (
    input  din, din_valid, shift_en,
    output din_ready, x_out, x_valid, x_last, busy
  );

endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the serial pattern detector. A word taken
// over valid/ready is emitted one bit per enabled clock on x_out; between
// words x_out rests at IDLE_BIT, optionally padded with gap cycles so that
// detector patterns cannot span two words.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  serial_bit_feeder_if.slave bus
);

  localparam int              CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
  localparam bit              HAS_GAP    = (GAP_CYCLES > 0);
  localparam logic [7:0]      GAP_LAST   = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;     // bits still to be shown, next one at the head
  logic [CNT_W-1:0] cnt;       // index of the bit currently on x_out
  logic [7:0]       gap_cnt;   // enabled gap cycles already spent
  logic             x_out_q;
  logic             x_valid_q;
  logic             x_last_q;
  logic             last_bit_done;
  logic             ready_c;
  logic             load;

  // Head of a word in transmission order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the head bit so the following bit becomes the new head.
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_bit_done = (state == SHIFT) && bus.shift_en && (cnt == CNT_LAST);

  // Ready in IDLE, or on the final enabled bit when words may run back-to-back.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal unassigned and a latch is inferred.
    ready_c = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    ready_c = 1'b1;
        SHIFT:   ready_c = !HAS_GAP && last_bit_done;
        default: ready_c = 1'b0;
      endcase
    end
  end

  assign load          = ready_c && bus.din_valid;
  assign bus.din_ready = ready_c;
  assign bus.x_out     = x_out_q;
  assign bus.x_valid   = x_valid_q;
  assign bus.x_last    = x_last_q;
  assign bus.busy      = (state != IDLE);

  // Sequencer: load, shift out, optional gap; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is reset too, so a word cut short by reset can never resurface.
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      x_out_q   <= IDLE_BIT;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state     <= SHIFT;
      shreg     <= drop_head(bus.din);
      cnt       <= '0;
      x_out_q   <= head_bit(bus.din);
      x_valid_q <= 1'b1;
      x_last_q  <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (bus.shift_en) begin
            if (cnt != CNT_LAST) begin
              cnt      <= cnt + 1'b1;
              shreg    <= drop_head(shreg);
              x_out_q  <= head_bit(shreg);
              x_last_q <= (cnt == CNT_PENULT);
            end else begin
              state     <= HAS_GAP ? GAP : IDLE;
              gap_cnt   <= '0;
              x_out_q   <= IDLE_BIT;
              x_valid_q <= 1'b0;
              x_last_q  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (bus.shift_en) begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
